// File: rtl/neuron_scheduler.sv
// neuron_scheduler
//
// Time-multiplexes one external Izhikevich state-update datapath across
// N_NEURONS neurons. Each start runs one network timestep: neurons are swept
// 0..N_NEURONS-1 through the datapath and their results are written back. A
// spike event is emitted for every neuron that fired.
//
// Input currents are double-buffered. The synapse logic accumulates into the
// write bank at any time. On start the banks swap, and the sweep consumes the
// read bank, clearing each entry as it goes.
//
// Ports
//   clk, asyn_reset                  clock (rising edge), async active-high reset
//   start / busy / done              sweep request, in-progress flag, completion pulse
//   i_wr_en, i_wr_idx, i_wr_data     saturating current accumulate into write bank
//   iz_v_in, iz_u_in, iz_i_in        registered operands to the datapath
//   iz_v_out, iz_u_out, iz_fired     datapath results, valid IZ_LAT cycles later
//   spike_valid, spike_idx,
//   spike_ready                      spike event handshake to the router
module neuron_scheduler #(
    parameter int          N_NEURONS = 16,
    parameter int          IDX_W     = 4,
    parameter int          IZ_LAT    = 1,
    parameter logic [16:0] V_INIT    = 17'h14100,
    parameter logic [16:0] U_INIT    = 17'h00000
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [16:0]      i_wr_data,
    output logic [16:0]      iz_v_in,
    output logic [16:0]      iz_u_in,
    output logic [16:0]      iz_i_in,
    input  logic [16:0]      iz_v_out,
    input  logic [16:0]      iz_u_out,
    input  logic             iz_fired,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic             spike_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_EMIT, S_DONE
    } state_t;

    // The WAIT counter runs from IZ_LAT-2 down to 0. WAIT lasts IZ_LAT-1 cycles.
    localparam int                CNT_W     = (IZ_LAT > 2) ? $clog2(IZ_LAT - 1) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'((IZ_LAT > 1) ? IZ_LAT - 2 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_NEURONS - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic               wr_bank_reg;

    logic [16:0] v_mem [N_NEURONS];
    logic [16:0] u_mem [N_NEURONS];
    logic [16:0] i_mem [2][N_NEURONS];

    logic             rd_bank;
    logic [IDX_W-1:0] idx_next;
    logic             advance;
    logic [16:0]      wr_old;
    logic [17:0]      wr_wide;
    logic [16:0]      wr_sum;
    logic [16:0]      start_i0;

    assign rd_bank  = ~wr_bank_reg;
    assign idx_next = idx_reg + IDX_W'(1);

    // Leaving WRITE without a spike, or completing the spike handshake in
    // EMIT, moves on to the next neuron or finishes the sweep.
    assign advance = ((state_reg == S_WRITE) && !iz_fired) ||
                     ((state_reg == S_EMIT)  && spike_ready);

    // Signed saturating accumulate. Overflow shows up as a mismatch between
    // the two top bits of the sign-extended sum.
    always_comb begin
        wr_old  = i_mem[wr_bank_reg][i_wr_idx];
        wr_wide = {wr_old[16], wr_old} + {i_wr_data[16], i_wr_data};
        if (wr_wide[17] != wr_wide[16]) begin
            wr_sum = wr_wide[17] ? 17'h10000 : 17'h0FFFF;
        end else begin
            wr_sum = wr_wide[16:0];
        end
    end

    // A write on the start cycle lands in the bank that becomes the read bank.
    // Forward it so neuron 0 sees it in the first ISSUE.
    assign start_i0 = (i_wr_en && (i_wr_idx == '0)) ? wr_sum : i_mem[wr_bank_reg][0];

    // Neuron state and current banks. The sweep only touches the read bank
    // and writers only touch the write bank, so the two ports never collide.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k]    <= V_INIT;
                u_mem[k]    <= U_INIT;
                i_mem[0][k] <= '0;
                i_mem[1][k] <= '0;
            end
        end else begin
            if (state_reg == S_WRITE) begin
                v_mem[idx_reg]          <= iz_v_out;
                u_mem[idx_reg]          <= iz_u_out;
                i_mem[rd_bank][idx_reg] <= '0;
            end
            if (i_wr_en) begin
                i_mem[wr_bank_reg][i_wr_idx] <= wr_sum;
            end
        end
    end

    // Sweep controller. Datapath operands are loaded on the edge that enters
    // ISSUE. They stay stable until the edge that closes WRITE.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            wr_bank_reg  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            spike_valid  <= 1'b0;
            spike_idx    <= '0;
            iz_v_in      <= '0;
            iz_u_in      <= '0;
            iz_i_in      <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        wr_bank_reg <= ~wr_bank_reg;
                        idx_reg     <= '0;
                        busy        <= 1'b1;
                        iz_v_in     <= v_mem[0];
                        iz_u_in     <= u_mem[0];
                        iz_i_in     <= start_i0;
                        state_reg   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (IZ_LAT > 1) begin
                        wait_cnt_reg <= WAIT_LOAD;
                        state_reg    <= S_WAIT;
                    end else begin
                        state_reg    <= S_WRITE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= S_WRITE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (iz_fired) begin
                        spike_valid <= 1'b1;
                        spike_idx   <= idx_reg;
                        state_reg   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    idx_reg   <= '0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase

            if (advance) begin
                if (idx_reg == LAST_IDX) begin
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end else begin
                    idx_reg   <= idx_next;
                    iz_v_in   <= v_mem[idx_next];
                    iz_u_in   <= u_mem[idx_next];
                    iz_i_in   <= i_mem[rd_bank][idx_next];
                    state_reg <= S_ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler
//
// Two schedulers share one clock: dut1 (IZ_LAT=1) and dut3 (IZ_LAT=3).
// use3 routes the stimulus to one of them and selects which one is observed.
// Each datapath stub returns v+1 and u+i after its latency. It fires when the
// presented current equals MAGIC.
module tb_neuron_scheduler;

    localparam int          N      = 16;
    localparam logic [16:0] V_INIT = 17'h14100;
    localparam logic [16:0] MAGIC  = 17'h00777;

    typedef struct packed {
        logic [16:0] v;
        logic [16:0] u;
        logic [16:0] i;
        logic        fire;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, rst3, start, i_wr_en, spike_ready, use3;
    logic [3:0]  i_wr_idx;
    logic [16:0] i_wr_data;

    logic        busy1, done1, sv1, f1;
    logic [3:0]  sidx1;
    logic [16:0] vin1, uin1, iin1, vout1, uout1;
    logic        busy3, done3, sv3;
    logic [3:0]  sidx3;
    logic [16:0] vin3, uin3, iin3, vout3, uout3;
    logic [16:0] p3v [3];
    logic [16:0] p3u [3];
    logic        p3f [3];

    logic        o_busy, o_done, o_sv;
    logic [3:0]  o_sidx;
    logic [16:0] o_v, o_u, o_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int hs_cnt   = 0;

    logic [16:0] m_v [N];
    logic [16:0] m_u [N];
    logic [16:0] m_acc [N];
    exp_t        exp_q [$];
    int          exp_spk [$];

    always #5 clk = ~clk;

    neuron_scheduler #(.N_NEURONS(N), .IDX_W(4), .IZ_LAT(1)) dut1 (
        .clk(clk), .asyn_reset(rst1), .start(start & ~use3),
        .busy(busy1), .done(done1),
        .i_wr_en(i_wr_en & ~use3), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .iz_v_in(vin1), .iz_u_in(uin1), .iz_i_in(iin1),
        .iz_v_out(vout1), .iz_u_out(uout1), .iz_fired(f1),
        .spike_valid(sv1), .spike_idx(sidx1), .spike_ready(spike_ready & ~use3)
    );

    neuron_scheduler #(.N_NEURONS(N), .IDX_W(4), .IZ_LAT(3)) dut3 (
        .clk(clk), .asyn_reset(rst3), .start(start & use3),
        .busy(busy3), .done(done3),
        .i_wr_en(i_wr_en & use3), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .iz_v_in(vin3), .iz_u_in(uin3), .iz_i_in(iin3),
        .iz_v_out(vout3), .iz_u_out(uout3), .iz_fired(p3f[2]),
        .spike_valid(sv3), .spike_idx(sidx3), .spike_ready(spike_ready & use3)
    );

    // Datapath stubs: dut1 has one register stage, dut3 has three.
    always @(posedge clk) begin
        vout1 <= vin1 + 17'd1;
        uout1 <= uin1 + iin1;
        f1    <= (iin1 == MAGIC);
        p3v[0] <= vin3 + 17'd1;
        p3u[0] <= uin3 + iin3;
        p3f[0] <= (iin3 == MAGIC);
        for (int s = 1; s < 3; s++) begin
            p3v[s] <= p3v[s-1];
            p3u[s] <= p3u[s-1];
            p3f[s] <= p3f[s-1];
        end
    end
    assign vout3 = p3v[2];
    assign uout3 = p3u[2];

    assign o_busy = use3 ? busy3 : busy1;
    assign o_done = use3 ? done3 : done1;
    assign o_sv   = use3 ? sv3   : sv1;
    assign o_sidx = use3 ? sidx3 : sidx1;
    assign o_v    = use3 ? vin3  : vin1;
    assign o_u    = use3 ? uin3  : uin1;
    assign o_i    = use3 ? iin3  : iin1;

    always @(posedge clk) begin
        if (o_sv && spike_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [16:0] sat17(input logic [16:0] a, input logic [16:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 65535) s = 65535;
        else if (s < -65536) s = -65536;
        return s[16:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k]   = V_INIT;
            m_u[k]   = 17'h0;
            m_acc[k] = 17'h0;
        end
        exp_q.delete();
        exp_spk.delete();
    endtask

    task automatic model_write(input int idx, input logic [16:0] d);
        m_acc[idx] = sat17(m_acc[idx], d);
    endtask

    // Snapshot the write bank as this timestep's currents. Queue the operands
    // each neuron should be issued with, and apply the stub update.
    task automatic model_start();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.v  = m_v[k];
            e.u  = m_u[k];
            e.i  = m_acc[k];
            e.fire = (m_acc[k] == MAGIC);
            m_acc[k] = 17'h0;
            exp_q.push_back(e);
            if (e.fire) exp_spk.push_back(k);
            m_v[k] = m_v[k] + 17'd1;
            m_u[k] = m_u[k] + e.i;
        end
    endtask

    task automatic wr_cur(input int idx, input logic [16:0] d);
        i_wr_en   = 1'b1;
        i_wr_idx  = idx[3:0];
        i_wr_data = d;
        model_write(idx, d);
        $display("write   idx=%0d data=%05h", idx, d);
        tick();
        i_wr_en = 1'b0;
    endtask

    // One full timestep. sw_idx>=0 adds a current write on the start cycle.
    // poke pulses start and writes neuron 0 while neuron 4 is in ISSUE.
    task automatic sweep(input int lat, input int stall, input int sw_idx,
                         input logic [16:0] sw_data, input bit poke);
        exp_t e;
        int   spk;
        int   nfire;
        int   hs0;
        if (sw_idx >= 0) begin
            i_wr_en   = 1'b1;
            i_wr_idx  = sw_idx[3:0];
            i_wr_data = sw_data;
            model_write(sw_idx, sw_data);
        end
        model_start();
        nfire = exp_spk.size();
        hs0   = hs_cnt;
        start = 1'b1;
        cyc   = 0;
        tick();
        start   = 1'b0;
        i_wr_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (exp_q.size() == 0) begin
                check_val("exp_q_underflow", 32'd1, 32'd0);
                break;
            end
            e = exp_q.pop_front();
            check_val($sformatf("issue%0d_v", k), 32'(o_v), 32'(e.v));
            check_val($sformatf("issue%0d_u", k), 32'(o_u), 32'(e.u));
            check_val($sformatf("issue%0d_i", k), 32'(o_i), 32'(e.i));
            check_val($sformatf("issue%0d_busy", k), 32'(o_busy), 32'd1);
            check_val($sformatf("issue%0d_done", k), 32'(o_done), 32'd0);
            if (poke && k == 4) begin
                start     = 1'b1;
                i_wr_en   = 1'b1;
                i_wr_idx  = 4'd0;
                i_wr_data = 17'h00055;
                model_write(0, 17'h00055);
            end
            tick();
            start   = 1'b0;
            i_wr_en = 1'b0;
            for (int w = 1; w < lat; w++) tick();
            check_val($sformatf("write%0d_i_hold", k), 32'(o_i), 32'(e.i));
            tick();
            if (e.fire) begin
                spk = (exp_spk.size() > 0) ? exp_spk.pop_front() : -1;
                for (int s = 0; s < stall; s++) begin
                    check_val($sformatf("stall%0d_valid", s), 32'(o_sv), 32'd1);
                    check_val($sformatf("stall%0d_idx", s), 32'(o_sidx), 32'(spk));
                    tick();
                end
                check_val("hs_valid", 32'(o_sv), 32'd1);
                check_val("hs_idx", 32'(o_sidx), 32'(spk));
                spike_ready = 1'b1;
                tick();
                spike_ready = 1'b0;
                $display("spike   idx=%0d after %0d stall cycles", spk, stall);
            end else begin
                check_val($sformatf("nospike%0d", k), 32'(o_sv), 32'd0);
            end
        end
        check_val("done_pulse", 32'(o_done), 32'd1);
        check_val("sweep_cycles", 32'(cyc), 32'(N * (lat + 1) + nfire * (stall + 1) + 1));
        tick();
        check_val("done_clear", 32'(o_done), 32'd0);
        check_val("busy_clear", 32'(o_busy), 32'd0);
        check_val("handshakes", 32'(hs_cnt - hs0), 32'(nfire));
        $display("sweep   lat=%0d spikes=%0d cycles=%0d", lat, nfire, cyc);
    endtask

    initial begin
        rst1 = 1'b0; rst3 = 1'b0; start = 1'b0; i_wr_en = 1'b0;
        spike_ready = 1'b0; use3 = 1'b0; i_wr_idx = 4'd0; i_wr_data = 17'h0;
        #1;
        rst1 = 1'b1;
        rst3 = 1'b1;
        #1;
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_done", 32'(o_done), 32'd0);
        check_val("rst_sv", 32'(o_sv), 32'd0);
        check_val("rst_sidx", 32'(o_sidx), 32'd0);
        check_val("rst_v", 32'(o_v), 32'd0);
        check_val("rst_u", 32'(o_u), 32'd0);
        check_val("rst_i", 32'(o_i), 32'd0);
        tick();
        tick();
        rst1 = 1'b0;
        rst3 = 1'b0;
        model_reset();
        tick();

        // Plain timestep: 33 busy cycles, v=V_INIT everywhere.
        sweep(1, 0, -1, 17'h0, 1'b0);
        // Accumulation, plus a write on the same cycle as start.
        wr_cur(3, 17'h00100);
        wr_cur(3, 17'h00100);
        sweep(1, 0, 7, 17'h00033, 1'b0);
        // The read bank was cleared, so idx 3 now sees 0.
        sweep(1, 0, -1, 17'h0, 1'b0);
        // Positive saturation.
        wr_cur(5, 17'h0FF00);
        wr_cur(5, 17'h00200);
        sweep(1, 0, -1, 17'h0, 1'b0);
        // Negative saturation and two stalled spikes.
        wr_cur(5, 17'h10100);
        wr_cur(5, 17'h1FE00);
        wr_cur(2, MAGIC);
        wr_cur(9, MAGIC);
        sweep(1, 4, -1, 17'h0, 1'b0);
        // start while busy is ignored. The mid-sweep write waits one timestep.
        sweep(1, 0, -1, 17'h0, 1'b1);
        sweep(1, 0, -1, 17'h0, 1'b0);

        // Asynchronous reset mid-sweep on the IZ_LAT=3 instance.
        use3 = 1'b1;
        model_reset();
        wr_cur(1, 17'h00040);
        sweep(3, 0, -1, 17'h0, 1'b0);
        wr_cur(2, 17'h00011);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        wr_cur(3, 17'h00022);
        #2;
        rst3 = 1'b1;
        #1;
        check_val("midrst_busy", 32'(o_busy), 32'd0);
        check_val("midrst_done", 32'(o_done), 32'd0);
        check_val("midrst_sv", 32'(o_sv), 32'd0);
        check_val("midrst_v", 32'(o_v), 32'd0);
        check_val("midrst_u", 32'(o_u), 32'd0);
        check_val("midrst_i", 32'(o_i), 32'd0);
        tick();
        tick();
        rst3 = 1'b0;
        model_reset();
        tick();
        sweep(3, 0, -1, 17'h0, 1'b0);
        sweep(3, 0, -1, 17'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neuron_scheduler.md
Name: neuron_scheduler

Overview:
Time-multiplexes one external Izhikevich state-update datapath across N_NEURONS neurons. Holds per-neuron v/u state and double-buffered input-current accumulators. On each `start` (one network timestep) it sweeps neurons 0..N_NEURONS-1 through the datapath, writes results back, and emits a spike event for every neuron that fired. It sits between the synapse/current-injection logic and the spike router.

Parameters:
N_NEURONS, 16, number of neurons; power of two, ≥2
IDX_W, 4, neuron index width; equals log2(N_NEURONS)
IZ_LAT, 1, datapath latency in cycles from stable inputs to valid outputs; ≥1
V_INIT, 17'h14100, v value loaded on reset
U_INIT, 17'h00000, u value loaded on reset

Ports:
clk  in  1  clock, rising edge
asyn_reset  in  1  asynchronous reset, active-high
start  in  1  begin one timestep sweep; accepted only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse when the sweep completes
i_wr_en  in  1  add i_wr_data to the current accumulator of neuron i_wr_idx
i_wr_idx  in  IDX_W  target neuron
i_wr_data  in  17  signed current increment, 17-bit two's complement fixed point
iz_v_in  out  17  v presented to the datapath
iz_u_in  out  17  u presented to the datapath
iz_i_in  out  17  accumulated current presented to the datapath
iz_v_out  in  17  next v from the datapath
iz_u_out  in  17  next u from the datapath
iz_fired  in  1  datapath fired flag
spike_valid  out  1  spike event valid
spike_idx  out  IDX_W  index of the neuron that fired
spike_ready  in  1  downstream accepts the spike event

Behaviour:
- Reset (asynchronous, immediate, valid mid-sweep): FSM goes to IDLE; busy=0, done=0, spike_valid=0, spike_idx=0, iz_v_in/iz_u_in/iz_i_in=0; every v=V_INIT, every u=U_INIT; both current banks cleared to 0; wr_bank=0; idx=0.
- FSM states: IDLE, ISSUE, WAIT, WRITE, EMIT, DONE.
- IDLE, start=1: swap banks (read bank ← old write bank) and set idx=0, then go to ISSUE. start in any other state is ignored.
- ISSUE (1 cycle): register iz_v_in=v[idx], iz_u_in=u[idx], iz_i_in=rd_bank[idx]. These values hold stable through WRITE.
- WAIT: lasts IZ_LAT-1 cycles, so it is skipped when IZ_LAT=1. A counter tracks the remaining cycles.
- WRITE (1 cycle): on the closing edge, v[idx]←iz_v_out, u[idx]←iz_u_out, rd_bank[idx]←0, and fired is latched.
  - If fired, go to EMIT.
  - Else, if idx==N_NEURONS-1, go to DONE.
  - Else, idx+1 and go to ISSUE.
- EMIT: spike_valid=1, spike_idx=idx. Hold until spike_valid&&spike_ready; on that edge drop valid and advance exactly as WRITE does for the not-fired case. Valid and idx must not change while stalled.
- DONE (1 cycle): done=1, then go to IDLE; idx returns to 0.
- Cost per neuron: IZ_LAT+1 cycles, plus ≥1 EMIT cycle if it fired.
- Current writes are accepted in every state and always target the write bank.
  - A write on the same cycle start is accepted lands in the bank that becomes the read bank, so it is included in this timestep.
  - Writes during a sweep never affect the sweep in progress.
- Accumulate arithmetic: signed 17-bit add with saturation to 17'h0FFFF / 17'h10000; no wrap.
- Only the read bank is cleared, per neuron, in WRITE. The write bank keeps accumulating until the next start.

Test Plan:
- Reset, then start with no current writes, IZ_LAT=1, datapath stub echoing v+1 and fired=0 → iz_v_in=17'h14100 for idx 0..15; done pulses exactly 33 cycles after start is sampled; no spike_valid; after the sweep, v[k]=17'h14101.
- Write 17'h00100 twice to idx 3, then start → iz_i_in=17'h00200 only during idx 3 ISSUE..WRITE; on the next sweep idx 3 sees iz_i_in=0.
- Write 17'h0FF00 then 17'h00200 to idx 5 → iz_i_in=17'h0FFFF (saturated); repeat with negative values → 17'h10000.
- Stub fires on idx 2 and idx 9, spike_ready held low 4 cycles each time → spike_valid high with spike_idx 2 for 4+ cycles, stable throughout, then 9; exactly two handshakes; done is delayed by the stall cycles.
- start pulsed while busy, and i_wr to idx 0 during the sweep → sweep is not restarted; the idx 0 write appears only in the next timestep.
- asyn_reset asserted mid-sweep with IZ_LAT=3 → outputs go to reset values immediately; the next start sweeps from idx 0 with v=V_INIT, u=U_INIT, and all currents 0.
